// File: rtl/gpio_in_cond_pkg.sv
// rtl/gpio_in_cond_pkg.sv - register addresses and default widths for gpio_in_cond
package gpio_in_cond_pkg;

  typedef logic [2:0] wb_adr_t;

  localparam wb_adr_t ADR_FILT     = 3'd0;
  localparam wb_adr_t ADR_IRQEN    = 3'd1;
  localparam wb_adr_t ADR_RISEEN   = 3'd2;
  localparam wb_adr_t ADR_FALLEN   = 3'd3;
  localparam wb_adr_t ADR_PEND     = 3'd4;
  localparam wb_adr_t ADR_PRESCALE = 3'd5;
  localparam wb_adr_t ADR_DBLEN    = 3'd6;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_PRE_W = 8;

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - one input bit: two-flop sync, tick-qualified debounce, edge pulses
module gpio_debounce_bit #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] db_len_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             filt_q, filt_d;
  logic             filt_prev_q, filt_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d        = pad_i;
    s2_d        = s1_q;
    filt_prev_d = filt_q;
    filt_d      = filt_q;
    cnt_d       = cnt_q;
    if (s2_q == filt_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      // >= keeps the count bounded if DB_LEN is lowered mid-count
      if (cnt_q >= db_len_i) begin
        filt_d = s2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      cnt_q       <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~filt_prev_q;
  assign fall_o = ~filt_q & filt_prev_q;

endmodule

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - GPIO input conditioning: debounce, edge capture, interrupt, Wishbone regs
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [2:0]       wb_adr_i,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [7:0]       wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_filt_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] db_len_q, db_len_d;
  logic [PRE_W-1:0] pc_q, pc_d;
  logic [7:0]       dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             irq_q, irq_d;

  logic             req, wr, rd, tick;
  logic [WIDTH-1:0] clr, filt, rise, fall;
  logic [7:0]       rdata;
  logic             unused_bus;

  assign unused_bus = ^{wb_cti_i, wb_bte_i};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(.CNT_W(CNT_W)) u_bit (
      .clk      (wb_clk),
      .rst_n    (wb_rst_n),
      .pad_i    (pad_i[i]),
      .tick_i   (tick),
      .db_len_i (db_len_q),
      .filt_o   (filt[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  always_comb begin
    req  = wb_cyc_i & wb_stb_i & ~ack_q;
    wr   = req & wb_we_i;
    rd   = req & ~wb_we_i;
    tick = (pc_q == prescale_q);

    irq_en_d   = irq_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    prescale_d = prescale_q;
    db_len_d   = db_len_q;
    clr        = '0;
    pc_d       = tick ? '0 : pc_q + 1'b1;

    if (wr) begin
      case (wb_adr_i)
        ADR_IRQEN:    irq_en_d  = wb_dat_i[WIDTH-1:0];
        ADR_RISEEN:   rise_en_d = wb_dat_i[WIDTH-1:0];
        ADR_FALLEN:   fall_en_d = wb_dat_i[WIDTH-1:0];
        ADR_PEND:     clr       = wb_dat_i[WIDTH-1:0];
        ADR_PRESCALE: begin
          prescale_d = wb_dat_i[PRE_W-1:0];
          pc_d       = '0;
        end
        ADR_DBLEN:    db_len_d  = wb_dat_i[CNT_W-1:0];
        default:      ;
      endcase
    end

    // a new edge in the same cycle as a W1C of that bit keeps it pending
    pend_d = (pend_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d  = |(pend_q & irq_en_q);

    case (wb_adr_i)
      ADR_FILT:     rdata = 8'(filt);
      ADR_IRQEN:    rdata = 8'(irq_en_q);
      ADR_RISEEN:   rdata = 8'(rise_en_q);
      ADR_FALLEN:   rdata = 8'(fall_en_q);
      ADR_PEND:     rdata = 8'(pend_q);
      ADR_PRESCALE: rdata = 8'(prescale_q);
      ADR_DBLEN:    rdata = 8'(db_len_q);
      default:      rdata = 8'h00;
    endcase

    dat_d = rd ? rdata : dat_q;
    ack_d = req;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pend_q     <= '0;
      prescale_q <= '0;
      db_len_q   <= '0;
      pc_q       <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pend_q     <= pend_d;
      prescale_q <= prescale_d;
      db_len_q   <= db_len_d;
      pc_q       <= pc_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign gpio_filt_o = filt;
  assign irq_o       = irq_q;

endmodule
